// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the writeback stage.
//   DATA_W  : datapath width
//   REG_W   : register address width
//   ECC_W   : SECDED check-bit width for a DATA_W word
//   result_src_e : writeback result select
package riscv_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int ECC_W  = 7;

   typedef enum logic {
      RESULT_ALU = 1'b0,
      RESULT_MEM = 1'b1
   } result_src_e;

endpackage

// File: rtl/writeback_cycle_if.sv
// MEM-to-WB stage bundle.
//   master : pipeline side; drives MEM-stage fields and StallW/FlushW, sees WB outputs
//   slave  : writeback stage; consumes MEM-stage fields, drives WB outputs
interface writeback_cycle_if;
   import riscv_pkg::*;

   logic              ValidM;
   logic              RegWriteM;
   logic              ResultSrcM;
   logic [REG_W-1:0]  RD_M;
   logic [DATA_W-1:0] ALUResultM;
   logic [DATA_W-1:0] ReadDataM;
   logic              StallW;
   logic              FlushW;

   logic              ValidW;
   logic              RegWriteW;
   logic [REG_W-1:0]  RDW;
   logic [DATA_W-1:0] ResultW;
   logic [ECC_W-1:0]  ECCW;
   logic [DATA_W-1:0] RetireCountW;

   modport master (
      output ValidM, RegWriteM, ResultSrcM, RD_M, ALUResultM, ReadDataM, StallW, FlushW,
      input  ValidW, RegWriteW, RDW, ResultW, ECCW, RetireCountW
   );

   modport slave (
      input  ValidM, RegWriteM, ResultSrcM, RD_M, ALUResultM, ReadDataM, StallW, FlushW,
      output ValidW, RegWriteW, RDW, ResultW, ECCW, RetireCountW
   );

endinterface

// File: rtl/writeback_cycle_secded.sv
// secded_encoder_32: combinational Hamming(38,32) + overall parity encoder.
//   data : 32-bit word to protect
//   ecc  : [5:0] Hamming parity for codeword positions 1,2,4,8,16,32;
//          [6] overall parity over data and ecc[5:0]
// Data bits occupy the non-power-of-two positions 3..38 in ascending order.
module secded_encoder_32
   import riscv_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [ECC_W-1:0]  ecc
);

   logic [5:0] hamming;
   int         dbit;

   always_comb begin
      hamming = '0;
      dbit    = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            for (int k = 0; k < 6; k++) begin
               if (((pos >> k) & 1) != 0) begin
                  hamming[k] = hamming[k] ^ data[dbit];
               end
            end
            dbit = dbit + 1;
         end
      end
   end

   assign ecc = {(^data) ^ (^hamming), hamming};

endmodule

// File: rtl/writeback_cycle.sv
// writeback_cycle: MEM/WB pipeline register and writeback datapath.
//   clk : rising-edge clock
//   rst : synchronous active-low reset (beats FlushW and StallW)
//   wb  : writeback_cycle_if.slave (MEM-stage inputs, StallW/FlushW, WB outputs)
// Optional build macro WB_ECC_EN: when defined, ECCW carries SECDED check bits
// for ResultW; otherwise ECCW is tied to zero and no encoder is built.
module writeback_cycle
   import riscv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   writeback_cycle_if.slave wb
);

   logic              valid_q;
   logic              regwrite_q;
   result_src_e       src_q;
   logic [REG_W-1:0]  rd_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] retire_q;
   logic [DATA_W-1:0] result;

   // Flush only squashes the control bits; payload fields keep their old
   // contents, which is harmless because nothing commits without valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         src_q      <= RESULT_ALU;
         rd_q       <= '0;
         alu_q      <= '0;
         rdata_q    <= '0;
         retire_q   <= '0;
      end else if (wb.FlushW) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (!wb.StallW) begin
         valid_q    <= wb.ValidM;
         regwrite_q <= wb.RegWriteM;
         src_q      <= result_src_e'(wb.ResultSrcM);
         rd_q       <= wb.RD_M;
         alu_q      <= wb.ALUResultM;
         rdata_q    <= wb.ReadDataM;
         if (wb.ValidM) begin
            retire_q <= retire_q + 1'b1;
         end
      end
   end

   assign result = (src_q == RESULT_MEM) ? rdata_q : alu_q;

   assign wb.ValidW       = valid_q;
   assign wb.RegWriteW    = valid_q & regwrite_q & (rd_q != '0);
   assign wb.RDW          = rd_q;
   assign wb.ResultW      = result;
   assign wb.RetireCountW = retire_q;

`ifdef WB_ECC_EN
   secded_encoder_32 u_ecc (
      .data (result),
      .ecc  (wb.ECCW)
   );
`else
   assign wb.ECCW = '0;
`endif

endmodule

// File: doc/writeback_cycle.md
WRITEBACK_CYCLE -- requirements
Module: writeback_cycle

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-003 SHALL have port ValidM, input, 1, MEM-stage slot holds a real instruction.
REQ-004 SHALL have port RegWriteM, input, 1, instruction writes a register.
REQ-005 SHALL have port ResultSrcM, input, 1, result select: 0 = ALU, 1 = load data.
REQ-006 SHALL have port RD_M, input, 5, destination register.
REQ-007 SHALL have port ALUResultM, input, 32, ALU result.
REQ-008 SHALL have port ReadDataM, input, 32, load data.
REQ-009 SHALL have port StallW, input, 1, hold the MEM/WB register.
REQ-010 SHALL have port FlushW, input, 1, load a bubble into the MEM/WB register.
REQ-011 SHALL have port ValidW, output, 1, WB slot valid.
REQ-012 SHALL have port RegWriteW, output, 1, register-file write enable for the decode stage.
REQ-013 SHALL have port RDW, output, 5, write address.
REQ-014 SHALL have port ResultW, output, 32, write data.
REQ-015 SHALL have port ECCW, output, 7, SECDED check bits for ResultW.
REQ-016 SHALL have port RetireCountW, output, 32, count of retired instructions.

Function
REQ-017 SHALL register ValidM, RegWriteM, ResultSrcM, RD_M, ALUResultM and ReadDataM on each rising edge when rst=1, StallW=0 and FlushW=0, giving 1-cycle latency from M inputs to W outputs.
REQ-018 SHALL hold all MEM/WB registers and the counter unchanged when StallW=1 and FlushW=0.
REQ-019 SHALL clear the stored valid and regwrite bits when FlushW=1, regardless of StallW; flush has priority over stall.
REQ-020 SHALL drive ResultW combinationally from the stored result select: stored ALU result when 0, stored load data when 1.
REQ-021 SHALL drive RegWriteW = stored valid AND stored regwrite AND (RDW != 0), so writes to x0 are never issued.
REQ-022 SHALL drive RDW directly from the stored destination register.
REQ-023 SHALL increment RetireCountW by 1 on each edge that captures ValidM=1 with StallW=0, FlushW=0 and rst=1.
REQ-024 SHALL wrap RetireCountW from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-025 SHALL compute ECCW as Hamming(38,32) plus an overall parity bit.
  - Codeword positions 1..38; parity bits sit at positions 1, 2, 4, 8, 16, 32.
  - ResultW bits 0..31 fill the remaining positions in ascending order.
  - ECCW[5:0] = parity at positions 1..32; each is the even parity of the positions whose index has that bit set.
  - ECCW[6] = XOR of all 32 data bits and ECCW[5:0].

Reset
REQ-026 SHALL, on a rising edge with rst=0, clear every MEM/WB register and RetireCountW to 0, giving ValidW=0, RegWriteW=0, RDW=0, ResultW=0, ECCW=0.
REQ-027 SHALL give rst priority over FlushW and StallW, including mid-stall.

Configuration
REQ-028 SHALL, when macro WB_ECC_EN is defined, instantiate the encoder and drive ECCW per REQ-025.
REQ-029 SHALL, when WB_ECC_EN is undefined, tie ECCW to 7'h00 and instantiate no encoder logic.

Structure
REQ-030 SHALL place the following in the shared package riscv_pkg:
  - data width (32), register address width (5) and check width (7);
  - result-select encodings RESULT_ALU = 0 and RESULT_MEM = 1.
REQ-031 SHALL implement the encoder as a purely combinational sub-module named secded_encoder_32.

Verification
REQ-032 SHALL cover: rst=0 for 2 cycles then rst=1 -> all outputs 0, RetireCountW=0.
REQ-033 SHALL cover: ValidM=1, RegWriteM=1, RD_M=5, ResultSrcM=0, ALUResultM=0x00000001 -> next cycle:
  - RegWriteW=1, RDW=5, ResultW=0x00000001;
  - ECCW=7'h43 with WB_ECC_EN defined, 7'h00 without;
  - RetireCountW=1.
REQ-034 SHALL cover: ResultSrcM=1, ReadDataM=0xDEADBEEF, RD_M=0 -> ResultW=0xDEADBEEF, RegWriteW=0, RetireCountW still increments.
REQ-035 SHALL cover: StallW=1 for 3 cycles while M inputs change -> W outputs and RetireCountW frozen; FlushW=1 with StallW=1 -> ValidW=0, RegWriteW=0 next cycle.
REQ-036 SHALL cover: RetireCountW preloaded to 0xFFFFFFFF via 2^32-1 valid captures or a force, then one valid capture -> 0x00000000.
REQ-037 SHALL cover: rst=0 asserted during a stall with a valid instruction held -> next cycle all outputs 0.
